// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between two byte sources, with burst lock.
// Optional WAIT watchdog is compiled in when UART_ARB_TIMEOUT_EN is defined.

module uart_tx_arbiter_chk #(
   parameter int unsigned TIMEOUT_CYCLES = 65535,
   parameter int unsigned TIMEOUT_W      = 16
) (
   input logic clk,
   input logic reset,
   input logic gnt0,
   input logic gnt1,
   input logic done0,
   input logic done1,
   input logic tx_en,
   input logic busy
);

   a_gnt_mutex: assert property (@(posedge clk) disable iff (!reset) !(gnt0 && gnt1));
   a_done0_owner: assert property (@(posedge clk) disable iff (!reset) done0 |-> gnt0);
   a_done1_owner: assert property (@(posedge clk) disable iff (!reset) done1 |-> gnt1);
   a_tx_en_pulse: assert property (@(posedge clk) disable iff (!reset) tx_en |=> !tx_en);
   a_tx_en_busy: assert property (@(posedge clk) disable iff (!reset) tx_en |-> busy);
   a_done_pulse: assert property (@(posedge clk) disable iff (!reset)
                                  (done0 || done1) |=> !(done0 || done1));
   a_timeout_fits: assert property (@(posedge clk)
                                    64'(TIMEOUT_CYCLES) <= ((64'd1 << TIMEOUT_W) - 64'd1));

endmodule

module uart_tx_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 65535,
   parameter int unsigned TIMEOUT_W      = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0,
   input  logic [7:0] data0,
   input  logic       lock0,
   output logic       gnt0,
   output logic       done0,
   input  logic       req1,
   input  logic [7:0] data1,
   input  logic       lock1,
   output logic       gnt1,
   output logic       done1,
   output logic       tx_en,
   output logic [7:0] tx_data,
   input  logic       tx_done,
   output logic       busy,
   output logic       timeout_err
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LAUNCH = 3'd1,
      ST_WAIT   = 3'd2,
      ST_DONE   = 3'd3,
      ST_HOLD   = 3'd4
   } state_t;

   state_t     state_r, state_s;
   logic       owner_r, owner_s;
   logic       last_served_r, last_served_s;
   logic [7:0] tx_data_r, tx_data_s;
   logic [1:0] gnt_r, gnt_s;
   logic [1:0] done_r, done_s;
   logic       tx_en_r, tx_en_s;
   logic       busy_r, busy_s;

   logic       req_own_s, lock_own_s, win_s, expire_s, keep_lock_s;
   logic [7:0] data_own_s, data_win_s;

   assign req_own_s  = owner_r ? req1 : req0;
   assign lock_own_s = owner_r ? lock1 : lock0;
   assign data_own_s = owner_r ? data1 : data0;
   // on a tie the requester that was not served last wins
   assign win_s      = (req0 && req1) ? ~last_served_r : req1;
   assign data_win_s = win_s ? data1 : data0;

`ifdef UART_ARB_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] to_cnt_r, to_cnt_s;
   logic                 abort_r, abort_s;
   logic                 timeout_err_r;

   assign expire_s    = (to_cnt_r == TIMEOUT_W'(TIMEOUT_CYCLES - 32'd1));
   // a real tx_done on the expiry cycle wins over the abort
   assign abort_s     = (state_r == ST_WAIT) && !tx_done && expire_s;
   assign keep_lock_s = lock_own_s & ~abort_r;
   assign timeout_err = timeout_err_r;

   // watchdog counter: cleared on WAIT entry, counts WAIT cycles
   always_comb begin
      to_cnt_s = to_cnt_r;
      if (state_r == ST_LAUNCH) begin
         to_cnt_s = {TIMEOUT_W{1'b0}};
      end else if (state_r == ST_WAIT) begin
         to_cnt_s = to_cnt_r + TIMEOUT_W'(1'b1);
      end else begin
         to_cnt_s = to_cnt_r;
      end
   end

   // watchdog registers and sticky error flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         to_cnt_r      <= {TIMEOUT_W{1'b0}};
         abort_r       <= 1'b0;
         timeout_err_r <= 1'b0;
      end else begin
         to_cnt_r      <= to_cnt_s;
         abort_r       <= abort_s;
         timeout_err_r <= timeout_err_r | abort_s;
      end
   end
`else
   assign expire_s    = 1'b0;
   assign keep_lock_s = lock_own_s;
   assign timeout_err = 1'b0;
`endif

   // next-state and next-output logic
   always_comb begin
      state_s       = state_r;
      owner_s       = owner_r;
      last_served_s = last_served_r;
      tx_data_s     = tx_data_r;
      gnt_s         = gnt_r;
      done_s        = 2'b00;
      tx_en_s       = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (req0 || req1) begin
               owner_s   = win_s;
               tx_data_s = data_win_s;
               gnt_s     = win_s ? 2'b10 : 2'b01;
               tx_en_s   = 1'b1;
               state_s   = ST_LAUNCH;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_LAUNCH: begin
            state_s = ST_WAIT;
         end
         ST_WAIT: begin
            if (tx_done || expire_s) begin
               done_s  = owner_r ? 2'b10 : 2'b01;
               state_s = ST_DONE;
            end else begin
               state_s = ST_WAIT;
            end
         end
         ST_DONE: begin
            last_served_s = owner_r;
            if (keep_lock_s) begin
               state_s = ST_HOLD;
            end else begin
               gnt_s   = 2'b00;
               state_s = ST_IDLE;
            end
         end
         ST_HOLD: begin
            if (req_own_s) begin
               tx_data_s = data_own_s;
               tx_en_s   = 1'b1;
               state_s   = ST_LAUNCH;
            end else if (!lock_own_s) begin
               gnt_s   = 2'b00;
               state_s = ST_IDLE;
            end else begin
               state_s = ST_HOLD;
            end
         end
         default: begin
            owner_s   = 1'b0;
            tx_data_s = 8'h00;
            gnt_s     = 2'b00;
            state_s   = ST_IDLE;
         end
      endcase
      busy_s = (state_s != ST_IDLE);
   end

   // state and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r       <= ST_IDLE;
         owner_r       <= 1'b0;
         last_served_r <= 1'b1;
         tx_data_r     <= 8'h00;
         gnt_r         <= 2'b00;
         done_r        <= 2'b00;
         tx_en_r       <= 1'b0;
         busy_r        <= 1'b0;
      end else begin
         state_r       <= state_s;
         owner_r       <= owner_s;
         last_served_r <= last_served_s;
         tx_data_r     <= tx_data_s;
         gnt_r         <= gnt_s;
         done_r        <= done_s;
         tx_en_r       <= tx_en_s;
         busy_r        <= busy_s;
      end
   end

   assign gnt0    = gnt_r[0];
   assign gnt1    = gnt_r[1];
   assign done0   = done_r[0];
   assign done1   = done_r[1];
   assign tx_en   = tx_en_r;
   assign tx_data = tx_data_r;
   assign busy    = busy_r;

   uart_tx_arbiter_chk #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .TIMEOUT_W      (TIMEOUT_W)
   ) u_chk (
      .clk   (clk),
      .reset (reset),
      .gnt0  (gnt0),
      .gnt1  (gnt1),
      .done0 (done0),
      .done1 (done1),
      .tx_en (tx_en),
      .busy  (busy)
   );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin/lock model.

module tb_uart_tx_arbiter;

`ifdef UART_ARB_TIMEOUT_EN
   localparam int unsigned TO_CYC = 100;
`else
   localparam int unsigned TO_CYC = 65535;
`endif

   logic       clk, reset;
   logic       req0, lock0, gnt0, done0;
   logic       req1, lock1, gnt1, done1;
   logic [7:0] data0, data1, tx_data;
   logic       tx_en, tx_done, busy, timeout_err;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   last_served;
   int   own;
   logic hold;
   logic exp_err;

   uart_tx_arbiter #(
      .TIMEOUT_CYCLES (TO_CYC),
      .TIMEOUT_W      (16)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req0        (req0),
      .data0       (data0),
      .lock0       (lock0),
      .gnt0        (gnt0),
      .done0       (done0),
      .req1        (req1),
      .data1       (data1),
      .lock1       (lock1),
      .gnt1        (gnt1),
      .done1       (done1),
      .tx_en       (tx_en),
      .tx_data     (tx_data),
      .tx_done     (tx_done),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // {gnt1, gnt0, done1, done0, tx_en, busy}
   function automatic logic [31:0] outs();
      return 32'({gnt1, gnt0, done1, done0, tx_en, busy});
   endfunction

   function automatic logic [31:0] ev(input int w, input logic g, input logic d,
                                      input logic te, input logic b);
      return 32'({g && (w == 1), g && (w == 0), d && (w == 1), d && (w == 0), te, b});
   endfunction

   // round robin: a lone requester wins, a tie goes to whoever was not served last
   function automatic int winner(input logic r0, input logic r1);
      if (r0 && r1) return (last_served == 0) ? 1 : 0;
      return r1 ? 1 : 0;
   endfunction

   task automatic drive_req(input logic r0, input logic r1, input logic [7:0] d0,
                            input logic [7:0] d1, input logic l0, input logic l1);
      req0 = r0; req1 = r1; data0 = d0; data1 = d1; lock0 = l0; lock1 = l1;
   endtask

   // Inputs already drive a grant/relaunch for the next edge. Checks LAUNCH and n WAIT
   // cycles (scrambling data meanwhile); with fire=1 pulses tx_done and checks DONE.
   task automatic launch_to_done(input int w, input logic [7:0] d, input int n, input logic fire);
      logic [7:0] s0, s1;
      s0 = data0; s1 = data1;
      @(negedge clk);
      check("launch", outs(), ev(w, 1'b1, 1'b0, 1'b1, 1'b1));
      check("launch_data", 32'(tx_data), 32'(d));
      data0 = 8'($urandom); data1 = 8'($urandom);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check("wait", outs(), ev(w, 1'b1, 1'b0, 1'b0, 1'b1));
         check("wait_data", 32'(tx_data), 32'(d));
         if (i == n - 1 && fire) tx_done = 1'b1;
      end
      data0 = s0; data1 = s1;
      if (fire) begin
         @(negedge clk);
         tx_done = 1'b0;
         check("done", outs(), ev(w, 1'b1, 1'b1, 1'b0, 1'b1));
         check("done_err", 32'(timeout_err), 32'(exp_err));
         last_served = w;
      end
   endtask

   // Called while DONE is observed: sets the owner's lock, scrambles req (ignored in DONE).
   task automatic after_done(input int w, input logic keep, output logic h);
      if (w == 0) lock0 = keep; else lock1 = keep;
      req0 = 1'($urandom); req1 = 1'($urandom);
      @(negedge clk);
      h = keep;
      check("post_done", outs(), keep ? ev(w, 1'b1, 1'b0, 1'b0, 1'b1) : 32'd0);
   endtask

   initial begin
      reset = 1'b0; tx_done = 1'b0; last_served = 1; exp_err = 1'b0; hold = 1'b0; own = 0;
      drive_req(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      check("reset_outs", outs(), 32'd0);
      check("reset_data", 32'(tx_data), 32'd0);
      check("reset_err", 32'(timeout_err), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      check("idle_after_reset", outs(), 32'd0);

      // contention from reset: 11, 22, 11
      drive_req(1'b1, 1'b1, 8'h11, 8'h22, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         launch_to_done(k % 2, (k % 2 == 1) ? 8'h22 : 8'h11, 2, 1'b1);
         @(negedge clk);
         check("rr_idle", outs(), 32'd0);
      end

      // single request
      drive_req(1'b1, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b0);
      launch_to_done(0, 8'hA5, 20, 1'b1);
      req0 = 1'b0;
      @(negedge clk);
      check("single_idle", outs(), 32'd0);

      // lock burst from requester 1 while requester 0 waits
      drive_req(1'b1, 1'b1, 8'h5A, 8'h01, 1'b0, 1'b1);
      launch_to_done(1, 8'h01, 3, 1'b1);
      req1 = 1'b0;
      @(negedge clk);
      check("burst_hold", outs(), ev(1, 1'b1, 1'b0, 1'b0, 1'b1));
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      check("hold_spurious", outs(), ev(1, 1'b1, 1'b0, 1'b0, 1'b1));
      req1 = 1'b1; data1 = 8'h02;
      launch_to_done(1, 8'h02, 2, 1'b1);
      data1 = 8'h03;
      @(negedge clk);
      check("burst_hold2", outs(), ev(1, 1'b1, 1'b0, 1'b0, 1'b1));
      launch_to_done(1, 8'h03, 2, 1'b1);
      lock1 = 1'b0; req1 = 1'b0;
      @(negedge clk);
      check("burst_release", outs(), 32'd0);
      launch_to_done(0, 8'h5A, 2, 1'b1);
      req0 = 1'b0;
      @(negedge clk);
      check("after_burst_idle", outs(), 32'd0);

      // spurious tx_done in IDLE
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      check("idle_spurious", outs(), 32'd0);

      // asynchronous reset during WAIT
      drive_req(1'b1, 1'b0, 8'h3C, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      check("rst_launch", outs(), ev(0, 1'b1, 1'b0, 1'b1, 1'b1));
      req0 = 1'b0;
      @(negedge clk);
      check("rst_wait", outs(), ev(0, 1'b1, 1'b0, 1'b0, 1'b1));
      #2 reset = 1'b0;
      #1;
      check("async_reset_outs", outs(), 32'd0);
      check("async_reset_data", 32'(tx_data), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      last_served = 1;
      drive_req(1'b0, 1'b1, 8'h00, 8'h77, 1'b0, 1'b0);
      launch_to_done(1, 8'h77, 3, 1'b1);
      req1 = 1'b0;
      @(negedge clk);
      check("post_reset_idle", outs(), 32'd0);

`ifdef UART_ARB_TIMEOUT_EN
      // tx_done on the expiry cycle completes normally
      drive_req(1'b1, 1'b0, 8'hC3, 8'h00, 1'b0, 1'b0);
      launch_to_done(0, 8'hC3, TO_CYC, 1'b1);
      req0 = 1'b0;
      @(negedge clk);
      check("expiry_done_idle", outs(), 32'd0);
      // withheld tx_done aborts after TO_CYC WAIT cycles, lock ignored
      drive_req(1'b1, 1'b0, 8'h96, 8'h00, 1'b1, 1'b0);
      launch_to_done(0, 8'h96, TO_CYC, 1'b0);
      req0 = 1'b0;
      @(negedge clk);
      exp_err = 1'b1;
      last_served = 0;
      check("timeout_done", outs(), ev(0, 1'b1, 1'b1, 1'b0, 1'b1));
      check("timeout_err_set", 32'(timeout_err), 32'(exp_err));
      @(negedge clk);
      check("timeout_idle", outs(), 32'd0);
      lock0 = 1'b0;
      drive_req(1'b0, 1'b1, 8'h00, 8'h42, 1'b0, 1'b0);
      launch_to_done(1, 8'h42, 3, 1'b1);
      req1 = 1'b0;
      @(negedge clk);
      check("err_sticky", 32'(timeout_err), 32'd1);
      reset = 1'b0;
      @(negedge clk);
      check("err_cleared", 32'(timeout_err), 32'd0);
      reset = 1'b1;
      exp_err = 1'b0;
      last_served = 1;
`else
      // without the watchdog WAIT never gives up
      drive_req(1'b1, 1'b0, 8'h96, 8'h00, 1'b0, 1'b0);
      launch_to_done(0, 8'h96, 150, 1'b1);
      req0 = 1'b0;
      @(negedge clk);
      check("long_wait_idle", outs(), 32'd0);
`endif

      // randomized traffic
      for (int it = 0; it < 120; it++) begin
         if (!hold) begin
            logic       r0, r1;
            logic [7:0] d0, d1;
            r0 = 1'($urandom); r1 = 1'($urandom);
            d0 = 8'($urandom); d1 = 8'($urandom);
            if (!r0 && !r1) begin
               drive_req(1'b0, 1'b0, d0, d1, 1'b0, 1'b0);
               tx_done = 1'($urandom);
               @(negedge clk);
               tx_done = 1'b0;
               check("rnd_idle", outs(), 32'd0);
            end else begin
               own = winner(r0, r1);
               drive_req(r0, r1, d0, d1, 1'($urandom), 1'($urandom));
               launch_to_done(own, (own == 1) ? d1 : d0, $urandom_range(1, 4), 1'b1);
               after_done(own, ($urandom_range(0, 2) == 0), hold);
            end
         end else begin
            logic [7:0] d;
            d = 8'($urandom);
            case ($urandom_range(0, 2))
               0: begin
                  req0 = 1'b1; req1 = 1'b1;
                  if (own == 0) data0 = d; else data1 = d;
                  launch_to_done(own, d, $urandom_range(1, 4), 1'b1);
                  after_done(own, 1'($urandom), hold);
               end
               1: begin
                  if (own == 0) begin
                     req0 = 1'b0; lock0 = 1'b1; req1 = 1'b1;
                  end else begin
                     req1 = 1'b0; lock1 = 1'b1; req0 = 1'b1;
                  end
                  tx_done = 1'($urandom);
                  @(negedge clk);
                  tx_done = 1'b0;
                  check("rnd_hold", outs(), ev(own, 1'b1, 1'b0, 1'b0, 1'b1));
               end
               default: begin
                  drive_req(1'b0, 1'b0, data0, data1, 1'b0, 1'b0);
                  @(negedge clk);
                  check("rnd_release", outs(), 32'd0);
                  hold = 1'b0;
               end
            endcase
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between two byte sources: requester 0 (instruction fetch unit) and requester 1 (bitty core).
- Replaces the plain select-driven muxing of tx data and tx enable.
- Grants are round-robin. An owner can lock the grant across a multi-byte burst.
- Generates the one-cycle tx_en pulse and returns a per-requester completion pulse.

Parameters:
TIMEOUT_CYCLES, 65535, cycles to wait for tx_done before aborting; used only with UART_ARB_TIMEOUT_EN.
TIMEOUT_W, 16, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
req0  input  1  requester 0 has a byte to send; level
data0  input  8  requester 0 byte; valid while req0=1
lock0  input  1  requester 0 keeps grant after current byte
gnt0  output  1  requester 0 owns transmitter
done0  output  1  one-cycle pulse: requester 0 byte finished
req1, data1, lock1, gnt1, done1  same meanings for requester 1
tx_en  output  1  one-cycle start pulse to UART
tx_data  output  8  registered byte to UART, stable from LAUNCH through WAIT
tx_done  input  1  UART transmit-complete pulse
busy  output  1  high in any state except IDLE
timeout_err  output  1  sticky abort flag; 0 when feature is compiled out

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; all outputs 0; tx_data=8'h00; owner=0.
  - last_served=1, so requester 0 wins the first tie.
  - Asserting reset mid-transfer aborts immediately, and tx_en never glitches high.
- All outputs are registered. The states are IDLE, LAUNCH, WAIT, DONE and HOLD.
- IDLE:
  - If exactly one reqN=1, grant it.
  - If both are high, grant the requester that is not last_served.
  - On grant: latch owner, tx_data<=dataN, gntN<=1, go to LAUNCH.
  - With no request, stay in IDLE.
- LAUNCH:
  - tx_en=1 for exactly this cycle, then go to WAIT.
  - Grant-to-tx_en latency is 1 cycle after the cycle in which req is sampled.
- WAIT:
  - Hold tx_data and the grant.
  - On tx_done=1, go to DONE.
  - Changes to req or data from the owner are ignored; the latched byte completes.
- DONE:
  - doneN=1 for the owner, for this cycle only.
  - Set last_served<=owner.
  - If lock[owner]=1 (sampled this cycle), go to HOLD with the grant kept.
  - Otherwise clear gntN and go to IDLE.
  - No request is sampled in DONE. This gives requesters one cycle to drop req after seeing done.
- HOLD:
  - If req[owner]=1, latch data[owner] and go to LAUNCH.
  - Otherwise, if lock[owner]=0, clear the grant and go to IDLE.
  - Otherwise stay in HOLD.
  - The other requester is blocked for the entire time HOLD is occupied.
- tx_done seen in IDLE, LAUNCH, DONE or HOLD is ignored and produces no done pulse.
- gnt0 and gnt1 are never both 1. doneN is only ever pulsed to the current owner.
- busy=1 in LAUNCH, WAIT, DONE and HOLD.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- Enabled:
  - The counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES-1 without tx_done, the arbiter goes to DONE and issues the owner's done pulse.
  - timeout_err<=1, sticky until reset.
  - lock is forced ignored for that DONE, so the arbiter always returns to IDLE.
  - tx_done in the same cycle as expiry takes priority: normal completion, no error.
- Disabled: WAIT waits indefinitely; timeout_err is tied to 0; no counter logic is present.

Test Plan:
- Single request: req0=1, data0=8'hA5, tx_done 20 cycles after tx_en.
  - Expect gnt0 high 1 cycle after req is sampled.
  - Expect tx_en one-cycle pulse with tx_data=8'hA5, then done0 one-cycle pulse 1 cycle after tx_done, then IDLE.
- Contention: req0 and req1 both high from reset, data0=8'h11, data1=8'h22.
  - Expect bytes 8'h11 then 8'h22, then 8'h11 again while both stay high.
  - gnt0 and gnt1 never overlap.
- Lock burst: lock1=1 with three bytes 8'h01, 8'h02, 8'h03 while req0 is held high.
  - Expect all three bytes from requester 1 to go out with gnt0=0 throughout.
  - After lock1 drops, requester 0 is served next.
- Spurious tx_done in IDLE and HOLD: no done pulse, no state change.
  - Data change on data0 during WAIT: tx_data stays at the latched value.
- Reset mid-WAIT: assert reset asynchronously.
  - All outputs go to 0 immediately. After release, req1 alone is granted normally.
- With UART_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=100: withhold tx_done.
  - Expect done0 after 100 WAIT cycles, timeout_err=1 sticky, then IDLE.
  - Repeat with tx_done exactly on the expiry cycle: timeout_err stays 0.
